cle_label_stats: RTL and testbench
==================================

# cle_label_stats

Post-labeling statistics stage for the connected-component labeling block. Once labeling has written a 32x32 label map into the label SRAM (one 8-bit label per pixel, address = row*32 + col, label 0 = background), a `start` pulse makes this block scan all 1024 entries. It accumulates area and bounding box for labels 1..MAX_LABELS. It then streams one record per non-empty label over a valid/ready interface.

## Interface
- MAX_LABELS, 16, number of tracked labels (1..MAX_LABELS); legal range 1..255.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- sram_a  output  10  label SRAM read address. Read is synchronous: sram_q is valid in the cycle after the address edge.
- sram_q  input  8  label SRAM read data.
- busy  output  1  high in SCAN and REPORT.
- done  output  1  one-cycle pulse after the last record.
- overflow  output  1  sticky; a label > MAX_LABELS was seen in the last scan.
- out_valid  output  1  a record is presented.
- out_ready  input  1  the consumer accepts the record.
- out_label  output  8  label id.
- out_area  output  11  pixel count, 1..1024.
- out_xmin, out_xmax, out_ymin, out_ymax  output  5 each  bounding box (col = x, row = y).

## Operation
- Reset values:
  - state IDLE; all outputs 0.
  - Table cleared: every area 0, mins 31, maxes 0.
  - Label index 1.
- States: IDLE -> SCAN -> REPORT -> DONE -> IDLE.
- IDLE:
  - On start: clear the table and overflow, set sram_a to 0, go to SCAN.
  - start at any other time is ignored.
- SCAN:
  - sram_a increments by 1 each cycle up to 1023, then holds.
  - A one-cycle-delayed valid/address pipeline tags each sram_q sample with its address a: row = a[9:5], col = a[4:0].
  - For each sample with label L:
    - L = 0: ignored.
    - 1 <= L <= MAX_LABELS: area[L] += 1; xmin/xmax/ymin/ymax[L] updated with col/row.
    - L > MAX_LABELS: overflow <= 1; no table update.
  - After the sample for address 1023 is accumulated, go to REPORT with index = 1.
- REPORT:
  - out_valid = (area[index] != 0). The out_* fields come combinationally from the table entry for index; out_label = index.
  - area[index] == 0: index advances in 1 cycle; out_valid stays low.
  - area[index] != 0: out_valid holds and all fields stay stable until the edge where out_ready = 1, then index advances.
  - out_ready asserted while out_valid = 0 has no effect.
  - The edge that retires index = MAX_LABELS moves to DONE.
  - Records are emitted in strictly ascending label order.
- DONE: done = 1 for exactly one cycle; busy = 0; go to IDLE.
- Width rules:
  - An area of 1024 needs the full 11 bits.
  - Bbox compares are unsigned 5-bit.
  - Index width is ceil(log2(MAX_LABELS+1)).
- Reset mid-operation: all state and outputs return to reset values immediately. The next start performs a complete, correct scan.

## Timing
- Edge 0 is the edge where start is sampled in IDLE.
- After edge 0: sram_a = 0 and busy = 1.
- After edge k (k = 0..1023): sram_a = k. The sample for address k is accumulated at edge k+2.
- The last accumulation is at edge 1025; the state is REPORT after edge 1025. Scan latency is 1025 cycles.
- REPORT takes MAX_LABELS cycles plus stall cycles. Stall cycles are those where out_valid = 1 and out_ready = 0.
- With zero stalls (MAX_LABELS = 16):
  - DONE after edge 1041, so done is high between edges 1041 and 1042.
  - IDLE after edge 1042.
  - busy is low from edge 1041 onward.
- overflow updates at the accumulation edge and holds until the next accepted start.

## Test plan
- All-zero map, start -> out_valid never asserts; busy high from edge 0 to edge 1041; one done pulse between edges 1041 and 1042; overflow = 0.
- Only address 37 = label 3, out_ready tied 1 -> exactly one record: label 3, area 1, xmin = xmax = 5, ymin = ymax = 1; done one cycle after the remaining skips.
- Entire map = label 1 -> one record: label 1, area 1024, bbox x 0..31, y 0..31.
- Labels 2 (rows 0-3, cols 0-3) and 5 (row 31, cols 10-20), out_ready low for 10 cycles at the first valid:
  - Label 2 (area 16, bbox 0..3/0..3) is held stable for all 10 cycles.
  - Then label 5 follows: area 11, x 10..20, y 31..31.
  - done arrives 10 cycles later than with no stall.
- Map containing label 200 and label 1 -> overflow = 1 after the scan; only label 1 is reported; a following scan of a clean map clears overflow.
- reset asserted while sram_a = 500 -> all outputs 0 at once. A start pulse while busy is ignored. A fresh start then reproduces the previous scenario's results exactly.

Source files
------------

// File: rtl/cle_label_stats.sv
// cle_label_stats: scans a 32x32 label map, accumulates per-label area and bounding box,
// then streams one record per non-empty label over valid/ready.
module cle_label_stats #(
   parameter int MAX_LABELS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [9:0]  sram_a,
   input  logic [7:0]  sram_q,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_label,
   output logic [10:0] out_area,
   output logic [4:0]  out_xmin,
   output logic [4:0]  out_xmax,
   output logic [4:0]  out_ymin,
   output logic [4:0]  out_ymax
);
   localparam int IW = $clog2(MAX_LABELS + 1);
   localparam logic [7:0] MAX8 = 8'(MAX_LABELS);
   localparam logic [IW-1:0] LAST = IW'(MAX_LABELS);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT, S_DONE} state_t;

   state_t state_q, state_d;
   logic [9:0] sram_a_q, sram_a_d, pa_q, pa_d;
   logic pv_q, pv_d, ovf_q, ovf_d;
   logic [IW-1:0] idx_q, idx_d, li;
   // Entry 0 is never used; it keeps the table directly indexable by label.
   logic [10:0] area_q [MAX_LABELS+1];
   logic [10:0] area_d [MAX_LABELS+1];
   logic [4:0] xmin_q [MAX_LABELS+1];
   logic [4:0] xmin_d [MAX_LABELS+1];
   logic [4:0] xmax_q [MAX_LABELS+1];
   logic [4:0] xmax_d [MAX_LABELS+1];
   logic [4:0] ymin_q [MAX_LABELS+1];
   logic [4:0] ymin_d [MAX_LABELS+1];
   logic [4:0] ymax_q [MAX_LABELS+1];
   logic [4:0] ymax_d [MAX_LABELS+1];

   assign li = sram_q[IW-1:0];

   always_comb begin
      state_d = state_q;
      sram_a_d = sram_a_q;
      pv_d = (state_q == S_SCAN);
      pa_d = sram_a_q;
      idx_d = idx_q;
      ovf_d = ovf_q;
      area_d = area_q;
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymin_d = ymin_q;
      ymax_d = ymax_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SCAN;
               sram_a_d = '0;
               ovf_d = 1'b0;
               for (int i = 0; i <= MAX_LABELS; i++) begin
                  area_d[i] = '0;
                  xmin_d[i] = 5'd31;
                  xmax_d[i] = '0;
                  ymin_d[i] = 5'd31;
                  ymax_d[i] = '0;
               end
            end
         end
         S_SCAN: begin
            sram_a_d = (sram_a_q == 10'd1023) ? sram_a_q : sram_a_q + 10'd1;
            if (pv_q) begin
               if (sram_q > MAX8) ovf_d = 1'b1;
               else if (sram_q != 8'd0) begin
                  area_d[li] = area_q[li] + 11'd1;
                  xmin_d[li] = (pa_q[4:0] < xmin_q[li]) ? pa_q[4:0] : xmin_q[li];
                  xmax_d[li] = (pa_q[4:0] > xmax_q[li]) ? pa_q[4:0] : xmax_q[li];
                  ymin_d[li] = (pa_q[9:5] < ymin_q[li]) ? pa_q[9:5] : ymin_q[li];
                  ymax_d[li] = (pa_q[9:5] > ymax_q[li]) ? pa_q[9:5] : ymax_q[li];
               end
               if (pa_q == 10'd1023) begin
                  state_d = S_REPORT;
                  idx_d = IW'(1);
               end
            end
         end
         S_REPORT: begin
            if (!out_valid || out_ready) begin
               idx_d = idx_q + IW'(1);
               if (idx_q == LAST) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sram_a_q <= '0;
         pv_q <= 1'b0;
         pa_q <= '0;
         idx_q <= IW'(1);
         ovf_q <= 1'b0;
         for (int i = 0; i <= MAX_LABELS; i++) begin
            area_q[i] <= '0;
            xmin_q[i] <= 5'd31;
            xmax_q[i] <= '0;
            ymin_q[i] <= 5'd31;
            ymax_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         sram_a_q <= sram_a_d;
         pv_q <= pv_d;
         pa_q <= pa_d;
         idx_q <= idx_d;
         ovf_q <= ovf_d;
         area_q <= area_d;
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymin_q <= ymin_d;
         ymax_q <= ymax_d;
      end
   end

   assign sram_a = sram_a_q;
   assign busy = (state_q == S_SCAN) || (state_q == S_REPORT);
   assign done = (state_q == S_DONE);
   assign overflow = ovf_q;
   assign out_valid = (state_q == S_REPORT) && (area_q[idx_q] != 11'd0);
   // Record fields read as zero whenever no record is presented.
   assign out_label = out_valid ? 8'(idx_q) : '0;
   assign out_area = out_valid ? area_q[idx_q] : '0;
   assign out_xmin = out_valid ? xmin_q[idx_q] : '0;
   assign out_xmax = out_valid ? xmax_q[idx_q] : '0;
   assign out_ymin = out_valid ? ymin_q[idx_q] : '0;
   assign out_ymax = out_valid ? ymax_q[idx_q] : '0;
endmodule

// File: tb/tb_cle_label_stats.sv
// tb_cle_label_stats: directed scans of hand-built label maps with hand-computed records,
// done timing, overflow, backpressure hold and mid-scan reset.
module tb_cle_label_stats;
   typedef logic [38:0] rec_t;

   logic clk = 1'b0;
   logic reset, start, out_ready, busy, done, overflow, out_valid;
   logic [9:0] sram_a;
   logic [7:0] sram_q, out_label;
   logic [10:0] out_area;
   logic [4:0] out_xmin, out_xmax, out_ymin, out_ymax;
   logic [7:0] mem [1024];
   rec_t cur;
   rec_t got[$];
   rec_t ex[$];
   int n_chk = 0, n_err = 0, done_edge, busy_fall;

   cle_label_stats #(.MAX_LABELS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .sram_a(sram_a), .sram_q(sram_q),
      .busy(busy), .done(done), .overflow(overflow), .out_valid(out_valid),
      .out_ready(out_ready), .out_label(out_label), .out_area(out_area),
      .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax)
   );

   always #5 clk = ~clk;
   always @(posedge clk) sram_q <= mem[sram_a];
   assign cur = {out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t mk(input int l, input int a, input int x0, input int x1, input int y0, input int y1);
      return {8'(l), 11'(a), 5'(x0), 5'(x1), 5'(y0), 5'(y1)};
   endfunction

   task automatic clear_map();
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
   endtask

   // One full scan; stall = cycles out_ready is held low at the first valid record,
   // restart = also pulse start while busy.
   task automatic run(input int stall, input bit restart);
      int e, left;
      rec_t held;
      bit hv;
      got.delete();
      done_edge = -1;
      busy_fall = -1;
      left = stall;
      hv = 1'b0;
      @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0; e = 0;
      chk("start_busy", busy, 1);
      chk("start_addr", sram_a, 0);
      while (done_edge < 0 && e < 3000) begin
         start = (restart && e == 10);
         if (e == 500) chk("addr500", sram_a, 500);
         if (!busy && busy_fall < 0) busy_fall = e;
         if (done) done_edge = e;
         if (out_valid) begin
            out_ready = (left == 0);
            if (out_ready) got.push_back(cur);
            else begin
               if (!hv) begin
                  held = cur;
                  hv = 1'b1;
               end else chk("stall_hold", cur, held);
               left--;
            end
         end else out_ready = 1'b1;
         @(posedge clk); #1 e++;
      end
      start = 1'b0;
      chk("timeout", done_edge >= 0, 1);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic cmp(input string tag, input int exp_done);
      chk({tag, "_count"}, got.size(), ex.size());
      for (int i = 0; i < ex.size() && i < got.size(); i++) chk({tag, "_rec"}, got[i], ex[i]);
      chk({tag, "_done"}, done_edge, exp_done);
      chk({tag, "_busy"}, busy_fall, exp_done);
   endtask

   task automatic map_two();
      clear_map();
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mem[r*32+c] = 8'd2;
      for (int c = 10; c <= 20; c++) mem[31*32+c] = 8'd5;
      ex = {mk(2, 16, 0, 3, 0, 3), mk(5, 11, 10, 20, 31, 31)};
   endtask

   initial begin
      int w;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      clear_map();
      repeat (2) @(posedge clk);
      #1 chk("rst_outs", {sram_a, busy, done, overflow, out_valid, cur}, 0);
      reset = 1'b0;

      ex.delete();
      run(0, 0); cmp("zero", 1041);
      chk("zero_ovf", overflow, 0);

      mem[37] = 8'd3;
      ex = {mk(3, 1, 5, 5, 1, 1)};
      run(0, 0); cmp("single", 1041);

      for (int i = 0; i < 1024; i++) mem[i] = 8'd1;
      ex = {mk(1, 1024, 0, 31, 0, 31)};
      run(0, 0); cmp("full", 1041);

      map_two();
      run(10, 0); cmp("stall", 1051);

      clear_map();
      mem[0] = 8'd1; mem[1023] = 8'd1; mem[100] = 8'd200;
      ex = {mk(1, 2, 0, 31, 0, 31)};
      run(0, 0); cmp("ovf", 1041);
      chk("ovf_set", overflow, 1);

      clear_map();
      mem[37] = 8'd3;
      ex = {mk(3, 1, 5, 5, 1, 1)};
      run(0, 0); cmp("clean", 1041);
      chk("ovf_clr", overflow, 0);

      map_two();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      w = 0;
      while (sram_a != 10'd500 && w < 2000) begin
         @(posedge clk); #1 w++;
      end
      chk("reach500", sram_a, 500);
      reset = 1'b1;
      #1 chk("midrst_outs", {sram_a, busy, done, overflow, out_valid, cur}, 0);
      @(posedge clk); #1 reset = 1'b0;
      run(10, 1); cmp("rerun", 1051);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
